// File: rtl/mux_nx1_stream.sv
// Registered N-to-1 stream mux with manual or round-robin select; one-cycle latency, one word per cycle.
// A stalled output (valid high, out_ready low) holds its word and drops every in_ready bit.
module mux_nx1_stream #(
  parameter  int N         = 8,
  parameter  int WIDTH     = 8,
  localparam int SEL_WIDTH = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic                 mode,
  input  logic [SEL_WIDTH-1:0] sel,
  output logic [WIDTH-1:0]     out_data,
  output logic [SEL_WIDTH-1:0] out_chan,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [WIDTH-1:0]     data_q, data_d;
  logic [SEL_WIDTH-1:0] chan_q, chan_d;
  logic [SEL_WIDTH-1:0] ptr_q, ptr_d;
  logic                 valid_q, valid_d;

  logic                 load;
  logic                 gnt_vld;
  logic [SEL_WIDTH-1:0] gnt_idx;
  logic [SEL_WIDTH-1:0] rr_idx;
  logic [WIDTH-1:0]     gnt_data;
  logic [31:0]          sel_ext;

  assign sel_ext = 32'(sel);
  assign load    = !valid_q || out_ready;

  // Grant is recomputed every cycle; nothing is latched between cycles.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    rr_idx  = '0;
    if (!mode) begin
      if (sel_ext < 32'(N) && in_valid[sel]) begin
        gnt_vld = 1'b1;
        gnt_idx = sel;
      end
    end else begin
      // Search ptr+1 .. ptr+N so the previous winner is considered last.
      for (int i = 1; i <= N; i++) begin
        rr_idx = SEL_WIDTH'((int'(ptr_q) + i) % N);
        if (!gnt_vld && in_valid[rr_idx]) begin
          gnt_vld = 1'b1;
          gnt_idx = rr_idx;
        end
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int k = 0; k < N; k++) begin
      if (gnt_idx == SEL_WIDTH'(k)) begin
        gnt_data = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign in_ready = (!rst && load && gnt_vld) ? (N'(1) << gnt_idx) : '0;

  always_comb begin
    data_d  = data_q;
    chan_d  = chan_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (load) begin
      valid_d = gnt_vld;
      if (gnt_vld) begin
        data_d = gnt_data;
        chan_d = gnt_idx;
        if (mode) begin
          ptr_d = gnt_idx;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
      ptr_q   <= SEL_WIDTH'(N - 1);
    end else begin
      data_q  <= data_d;
      chan_q  <= chan_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_data  = data_q;
  assign out_chan  = chan_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_mux_nx1_stream.sv
// Bench for mux_nx1_stream: directed scenarios with literal expectations plus a randomized run
// checked every cycle against a queue-free behavioural model of the output register and arbiter.
module tb_mux_nx1_stream;

  localparam int N  = 8;
  localparam int W  = 8;
  localparam int SW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic            mode;
  logic [SW-1:0]   sel;
  logic [W-1:0]    out_data;
  logic [SW-1:0]   out_chan;
  logic            out_valid;
  logic            out_ready;

  mux_nx1_stream #(.N(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what the single output slot should hold and who won last in round-robin.
  bit         chk_en = 1'b0;
  bit         m_valid;
  logic [7:0] m_data;
  int         m_chan;
  int         m_ptr;

  function automatic int model_grant();
    int c;
    if (!mode) begin
      if (int'(sel) < N && in_valid[sel]) return int'(sel);
      return -1;
    end
    for (int k = 1; k <= N; k++) begin
      c = (m_ptr + k) % N;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [31:0] model_ready();
    int g;
    if (rst) return 32'd0;
    if (m_valid && !out_ready) return 32'd0;
    g = model_grant();
    if (g < 0) return 32'd0;
    return 32'd1 << g;
  endfunction

  always @(posedge clk) begin
    int g;
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= 8'h00;
      m_chan  <= 0;
      m_ptr   <= N - 1;
      chk_en  <= 1'b1;
    end else if (!m_valid || out_ready) begin
      g = model_grant();
      if (g >= 0) begin
        m_valid <= 1'b1;
        m_data  <= in_data[g*W +: W];
        m_chan  <= g;
        if (mode) m_ptr <= g;
      end else begin
        m_valid <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_in_ready", 32'(in_ready), model_ready());
      check("model_out_valid", 32'(out_valid), 32'(m_valid));
      check("model_out_data", 32'(out_data), 32'(m_data));
      check("model_out_chan", 32'(out_chan), 32'(m_chan));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [N*W-1:0] pat;
  logic [7:0]     sweep_exp [8];

  initial begin
    pat = 64'hAABBCCDD11223344;
    sweep_exp = '{8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA};

    rst       = 1'b1;
    mode      = 1'b0;
    sel       = '0;
    in_valid  = '0;
    out_ready = 1'b1;
    in_data   = pat;
    step();
    step();
    rst = 1'b0;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", 32'(out_data), 32'h00);
    check("reset_out_chan", 32'(out_chan), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd0);

    // Manual sweep
    in_valid = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      sel = SW'(k);
      #1;
      check("sweep_in_ready", 32'(in_ready), 32'd1 << k);
      step();
      check("sweep_out_data", 32'(out_data), 32'(sweep_exp[k]));
      check("sweep_out_chan", 32'(out_chan), 32'(k));
      check("sweep_out_valid", 32'(out_valid), 32'd1);
    end

    // Round-robin fairness from reset
    rst = 1'b1;
    step();
    rst  = 1'b0;
    mode = 1'b1;
    in_valid = 8'hFF;
    for (int i = 0; i < 16; i++) begin
      step();
      check("rr_out_chan", 32'(out_chan), 32'(i % 8));
      check("rr_out_valid", 32'(out_valid), 32'd1);
    end

    // Sparse requests on channels 2 and 5
    in_valid = 8'h24;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("sparse_in_ready_other", 32'(in_ready & ~8'h24), 32'd0);
      step();
      check("sparse_out_chan", 32'(out_chan), (i % 2 == 0) ? 32'd2 : 32'd5);
    end

    // Backpressure holding CC, then drain and reload with no bubble
    mode = 1'b0;
    sel  = 3'd5;
    in_valid = 8'hFF;
    step();
    check("bp_load_data", 32'(out_data), 32'hCC);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_in_ready", 32'(in_ready), 32'd0);
      step();
      check("bp_out_data", 32'(out_data), 32'hCC);
      check("bp_out_valid", 32'(out_valid), 32'd1);
    end
    sel = 3'd6;
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 32'(in_ready), 32'h40);
    step();
    check("bp_release_data", 32'(out_data), 32'hBB);
    check("bp_release_valid", 32'(out_valid), 32'd1);
    check("bp_release_chan", 32'(out_chan), 32'd6);

    // Empty selection
    sel = 3'd3;
    in_valid = 8'hF7;
    step();
    check("empty_out_valid", 32'(out_valid), 32'd0);
    check("empty_out_data", 32'(out_data), 32'hBB);

    // Reset mid-operation in round-robin mode
    mode = 1'b1;
    in_valid = 8'hFF;
    step();
    check("midrst_pre_valid", 32'(out_valid), 32'd1);
    check("midrst_pre_chan", 32'(out_chan), 32'd6);
    rst = 1'b1;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    step();
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data", 32'(out_data), 32'h00);
    check("midrst_out_chan", 32'(out_chan), 32'd0);
    rst = 1'b0;
    in_valid = 8'h18;
    step();
    check("midrst_first_chan", 32'(out_chan), 32'd3);
    check("midrst_first_data", 32'(out_data), 32'h11);

    // Randomized run, checked by the per-cycle model comparison
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 149) == 0);
      mode      = ($urandom_range(0, 9) < 6);
      sel       = SW'($urandom);
      case ($urandom_range(0, 3))
        0:       in_valid = 8'hFF;
        1:       in_valid = 8'h00;
        default: in_valid = N'($urandom);
      endcase
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = {$urandom(), $urandom()};
      step();
    end

    rst = 1'b0;
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
